// File: rtl/mode_sched.sv
// Frame-synchronous mode scheduler: button requests are shown immediately on the
// LEDs and committed to the pixel path only on a vs_i rising edge or while video is absent.
`timescale 1ns/1ps
module mode_sched #(
   parameter logic [2:0] RST_MODE = 3'd2,
   parameter int         TIMEOUT  = 4194304,
   parameter int         CW       = $clog2(TIMEOUT)
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       next_i,
   input  logic       flip_i,
   input  logic       bypass_i,
   input  logic       vs_i,
   output logic [2:0] mode_o,
   output logic [2:0] req_o,
   output logic [3:0] led_o,
   output logic       pending_o,
   output logic       apply_o,
   output logic       sig_o
);

   localparam logic [0:0]    ST_NOSIG = 1'b0;
   localparam logic [0:0]    ST_SIG   = 1'b1;
   localparam logic [2:0]    DIRECT   = 3'd0;
   localparam logic [CW-1:0] WD_LAST  = CW'(TIMEOUT - 1);

   function automatic logic [3:0] led_decode(input logic [2:0] m);
      logic [3:0] d;
      d[3] = m[0];
      for (int i = 0; i < 3; i++) begin
         d[i] = (m[2:1] == 2'(i + 1));
      end
      return d;
   endfunction

   logic [2:0]    req_reg, req_next;
   logic [2:0]    cur_reg, cur_next;
   logic          byp_reg, byp_next;
   logic          vs_reg;
   logic [CW-1:0] wd_reg, wd_next;
   logic [0:0]    state_reg, state_next;
   logic          rise, commit, changed;
   logic [2:0]    mode_next;
   logic          pending_next;

   always_comb begin
      req_next = req_reg;
      if (next_i) req_next[2:1] = req_reg[2:1] + 2'd1;
      if (flip_i) req_next[0]   = ~req_reg[0];
   end

   // Commit uses req_reg, so a request landing on the rise cycle waits for the next one.
   assign rise         = vs_i & ~vs_reg;
   assign commit       = (state_reg == ST_NOSIG) | rise;
   assign cur_next     = commit ? req_reg  : cur_reg;
   assign byp_next     = commit ? bypass_i : byp_reg;
   assign changed      = commit & ({bypass_i, req_reg} != {byp_reg, cur_reg});
   assign mode_next    = byp_next ? DIRECT : cur_next;
   assign pending_next = (req_next != cur_next) | (bypass_i != byp_next);

   always_comb begin
      state_next = state_reg;
      wd_next    = wd_reg;
      if (rise) begin
         state_next = ST_SIG;
         wd_next    = '0;
      end else if (state_reg == ST_SIG) begin
         if (wd_reg == WD_LAST) begin
            state_next = ST_NOSIG;
            wd_next    = '0;
         end else begin
            wd_next = wd_reg + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         req_reg   <= RST_MODE;
         cur_reg   <= RST_MODE;
         byp_reg   <= 1'b0;
         vs_reg    <= 1'b0;
         wd_reg    <= '0;
         state_reg <= ST_NOSIG;
         mode_o    <= RST_MODE;
         led_o     <= led_decode(RST_MODE);
         pending_o <= 1'b0;
         apply_o   <= 1'b0;
      end else begin
         req_reg   <= req_next;
         cur_reg   <= cur_next;
         byp_reg   <= byp_next;
         vs_reg    <= vs_i;
         wd_reg    <= wd_next;
         state_reg <= state_next;
         mode_o    <= mode_next;
         led_o     <= led_decode(req_next);
         pending_o <= pending_next;
         apply_o   <= changed;
      end
   end

   assign req_o = req_reg;
   assign sig_o = (state_reg == ST_SIG);

endmodule

// File: tb/tb_mode_sched.sv
// Self-checking bench for mode_sched: per-cycle comparison against a frame-level
// model plus hand-computed checkpoints along a directed scenario.
`timescale 1ns/1ps
module tb_mode_sched;

   localparam int TIMEOUT = 4096;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       next_i = 1'b0;
   logic       flip_i = 1'b0;
   logic       bypass_i = 1'b0;
   logic       vs_i = 1'b0;
   logic [2:0] mode_o;
   logic [2:0] req_o;
   logic [3:0] led_o;
   logic       pending_o;
   logic       apply_o;
   logic       sig_o;

   int checks = 0;
   int passed = 0;

   mode_sched #(
      .RST_MODE(3'd2),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .next_i   (next_i),
      .flip_i   (flip_i),
      .bypass_i (bypass_i),
      .vs_i     (vs_i),
      .mode_o   (mode_o),
      .req_o    (req_o),
      .led_o    (led_o),
      .pending_o(pending_o),
      .apply_o  (apply_o),
      .sig_o    (sig_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask

   // LED pattern per mode, straight from the indicator table.
   logic [3:0] led_tab [8] = '{4'b0000, 4'b1000, 4'b0001, 4'b1001,
                               4'b0010, 4'b1010, 4'b0100, 4'b1100};

   // Model: video is present for TIMEOUT cycles after each vs rising edge.
   int         cyc_no;
   int         last_rise;
   bit         m_prev_vs;
   logic [2:0] m_cur;
   bit         m_byp;
   logic [2:0] e_req, e_mode;
   logic [3:0] e_led;
   bit         e_pend, e_apply, e_sig;
   int         fam, lt;
   logic [2:0] old_req, new_req;
   bit         frame_edge, now_video;

   function automatic bit video_at(input int c);
      return (last_rise >= 0) && (c > last_rise) && (c - last_rise <= TIMEOUT);
   endfunction

   task automatic model_reset();
      cyc_no = 0; last_rise = -1; m_prev_vs = 0;
      m_cur = 3'd2; m_byp = 0;
      e_req = 3'd2; e_mode = 3'd2; e_led = 4'b0001;
      e_pend = 0; e_apply = 0; e_sig = 0;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk_i or negedge rst_ni);
         if (!rst_ni) begin
            model_reset();
         end else begin
            now_video = video_at(cyc_no);
            old_req = e_req;
            fam = int'(old_req) / 2;
            lt  = int'(old_req) % 2;
            if (next_i) fam = (fam + 1) % 4;
            if (flip_i) lt = 1 - lt;
            new_req = 3'(fam * 2 + lt);
            frame_edge = vs_i && !m_prev_vs;
            m_prev_vs = vs_i;
            if (!now_video || frame_edge) begin
               e_apply = (bypass_i != m_byp) || (old_req != m_cur);
               m_cur = old_req;
               m_byp = bypass_i;
            end else begin
               e_apply = 0;
            end
            if (frame_edge) last_rise = cyc_no;
            cyc_no++;
            e_sig  = video_at(cyc_no);
            e_req  = new_req;
            e_led  = led_tab[new_req];
            e_mode = m_byp ? 3'd0 : m_cur;
            e_pend = (new_req != m_cur) || (bypass_i != m_byp);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk_i);
         chk("mode_o",    int'(mode_o),    int'(e_mode));
         chk("req_o",     int'(req_o),     int'(e_req));
         chk("led_o",     int'(led_o),     int'(e_led));
         chk("pending_o", int'(pending_o), int'(e_pend));
         chk("apply_o",   int'(apply_o),   int'(e_apply));
         chk("sig_o",     int'(sig_o),     int'(e_sig));
      end
   end

   // Drive one cycle of inputs; returns 1 time unit after the sampling edge.
   task automatic cyc(input logic v, input logic n, input logic f, input logic b);
      vs_i = v; next_i = n; flip_i = f; bypass_i = b;
      @(posedge clk_i);
      #1;
   endtask

   logic vsv, nx, fl, bp;

   initial begin
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst mode_o", int'(mode_o), 2);
      chk("rst led_o", int'(led_o), 4'b0001);
      chk("rst sig_o", int'(sig_o), 0);
      rst_ni = 1'b1;

      // NOSIG: immediate commit
      cyc(0, 1, 0, 0);
      chk("nosig req_o", int'(req_o), 4);
      chk("nosig led_o", int'(led_o), 4'b0010);
      chk("nosig mode_o early", int'(mode_o), 2);
      cyc(0, 0, 0, 0);
      chk("nosig mode_o", int'(mode_o), 4);
      chk("nosig apply_o", int'(apply_o), 1);
      cyc(0, 0, 0, 0);
      chk("nosig apply_o once", int'(apply_o), 0);

      // 4 -> 6 -> 0 -> 2, then next+flip together
      repeat (3) cyc(0, 1, 0, 0);
      chk("wrap req_o", int'(req_o), 2);
      cyc(0, 1, 1, 0);
      chk("next+flip req_o", int'(req_o), 5);
      cyc(0, 1, 0, 0);
      chk("req_o 7", int'(req_o), 7);
      cyc(0, 1, 0, 0);
      chk("wrap from 7", int'(req_o), 1);
      cyc(0, 1, 0, 0);
      chk("req_o 3", int'(req_o), 3);
      cyc(0, 1, 0, 0);
      chk("req_o 5", int'(req_o), 5);
      chk("led_o 5 late", int'(led_o), 4'b1010);

      rst_ni = 1'b0;
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      chk("re-reset mode_o", int'(mode_o), 2);

      // Framed video: rises at k = 500, 1500, ..., 4500; then vs stops.
      for (int k = 0; k <= 8700; k++) begin
         vsv = (k < 4600) && ((k % 1000) >= 500) && ((k % 1000) < 510);
         nx  = (k == 800) || (k == 5000) || (k == 8700);
         fl  = (k == 3500);
         bp  = (k >= 1800) && (k < 2700);
         cyc(vsv, nx, fl, bp);
         if (k == 1000) begin
            chk("frame hold mode_o", int'(mode_o), 2);
            chk("frame pending_o", int'(pending_o), 1);
            chk("frame req_o", int'(req_o), 4);
            chk("frame sig_o", int'(sig_o), 1);
         end
         if (k == 1500) begin
            chk("rise mode_o", int'(mode_o), 4);
            chk("rise pending_o", int'(pending_o), 0);
            chk("rise apply_o", int'(apply_o), 1);
         end
         if (k == 2000) begin
            chk("bypass hold mode_o", int'(mode_o), 4);
            chk("bypass pending_o", int'(pending_o), 1);
         end
         if (k == 2500) begin
            chk("bypass mode_o", int'(mode_o), 0);
            chk("bypass apply_o", int'(apply_o), 1);
            chk("bypass req_o", int'(req_o), 4);
         end
         if (k == 3000) chk("unbypass pending_o", int'(pending_o), 1);
         if (k == 3500) begin
            chk("restore mode_o", int'(mode_o), 4);
            chk("restore apply_o", int'(apply_o), 1);
            chk("rise-cycle req_o", int'(req_o), 5);
            chk("rise-cycle pending_o", int'(pending_o), 1);
         end
         if (k == 4500) begin
            chk("late commit mode_o", int'(mode_o), 5);
            chk("late commit pending_o", int'(pending_o), 0);
         end
         if (k == 8595) chk("wd sig_o still", int'(sig_o), 1);
         if (k == 8596) begin
            chk("wd sig_o drop", int'(sig_o), 0);
            chk("wd mode_o before", int'(mode_o), 5);
         end
         if (k == 8597) begin
            chk("wd commit mode_o", int'(mode_o), 7);
            chk("wd commit apply_o", int'(apply_o), 1);
         end
         if (k == 8700) begin
            chk("pre-reset pending_o", int'(pending_o), 1);
            chk("pre-reset req_o", int'(req_o), 1);
         end
      end

      // Asynchronous reset mid-cycle while a request is pending
      #2;
      rst_ni = 1'b0;
      #1;
      chk("async mode_o", int'(mode_o), 2);
      chk("async req_o", int'(req_o), 2);
      chk("async led_o", int'(led_o), 4'b0001);
      chk("async pending_o", int'(pending_o), 0);
      chk("async apply_o", int'(apply_o), 0);
      chk("async sig_o", int'(sig_o), 0);
      repeat (3) @(posedge clk_i);
      #1;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
